// File: rtl/counter_arb_pkg.sv
// Shared definitions for the counter request arbiter: op encodings and
// pointer width helper.
package counter_arb_pkg;

    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_SET   = 2'b01,
        OP_FORCE = 2'b10,
        OP_READ  = 2'b11
    } op_e;

    function automatic int unsigned ptr_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/counter_req_arbiter_rr_scan.sv
// Combinational round-robin scan: walks requesters from ptr, packs up to two
// ADDs and one SET, or a single exclusive FORCE/READ, and computes next ptr.
module rr_scan
    import counter_arb_pkg::*;
#(
    parameter int unsigned nreq = 4,
    parameter int unsigned pw   = ptr_w(nreq)
) (
    input  logic [nreq-1:0]   valid,
    input  logic [2*nreq-1:0] op,
    input  logic [pw-1:0]     ptr,
    input  logic              stage_busy,
    output logic [nreq-1:0]   grant,
    output logic              a_en,
    output logic [pw-1:0]     a_idx,
    output logic              b_en,
    output logic [pw-1:0]     b_idx,
    output logic              c_en,
    output logic [pw-1:0]     c_idx,
    output logic              f_en,
    output logic              r_en,
    output logic [pw-1:0]     fr_idx,
    output logic [pw-1:0]     next_ptr
);

    int unsigned idx;
    int unsigned idx_inc;
    logic        stop;
    logic        first;
    op_e         cur;

    always_comb begin
        grant    = '0;
        a_en     = 1'b0;
        a_idx    = '0;
        b_en     = 1'b0;
        b_idx    = '0;
        c_en     = 1'b0;
        c_idx    = '0;
        f_en     = 1'b0;
        r_en     = 1'b0;
        fr_idx   = '0;
        next_ptr = ptr;
        stop     = 1'b0;
        first    = 1'b1;
        idx      = 0;
        idx_inc  = 0;
        cur      = OP_ADD;
        for (int unsigned k = 0; k < nreq; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= nreq) idx = idx - nreq;
            idx_inc = (idx + 1 >= nreq) ? 0 : idx + 1;
            if (!stop && valid[idx]) begin
                cur = op_e'(op[2*idx +: 2]);
                case (cur)
                    OP_FORCE: begin
                        if (first) begin
                            grant[idx] = 1'b1;
                            f_en       = 1'b1;
                            fr_idx     = pw'(idx);
                            next_ptr   = pw'(idx_inc);
                        end
                        stop = 1'b1;
                    end
                    // A READ behind other traffic, or with the stage busy, stalls the scan.
                    OP_READ: begin
                        if (first && !stage_busy) begin
                            grant[idx] = 1'b1;
                            r_en       = 1'b1;
                            fr_idx     = pw'(idx);
                            next_ptr   = pw'(idx_inc);
                        end
                        stop = 1'b1;
                    end
                    OP_ADD: begin
                        if (!a_en) begin
                            grant[idx] = 1'b1;
                            a_en       = 1'b1;
                            a_idx      = pw'(idx);
                            next_ptr   = pw'(idx_inc);
                        end else if (!b_en) begin
                            grant[idx] = 1'b1;
                            b_en       = 1'b1;
                            b_idx      = pw'(idx);
                            next_ptr   = pw'(idx_inc);
                        end
                    end
                    OP_SET: begin
                        if (!c_en) begin
                            grant[idx] = 1'b1;
                            c_en       = 1'b1;
                            c_idx      = pw'(idx);
                            next_ptr   = pw'(idx_inc);
                        end
                    end
                endcase
                first = 1'b0;
            end
        end
    end

endmodule

// File: rtl/counter_req_arbiter.sv
// Shares one Counter among nreq valid/ready requesters; holds the rr pointer,
// the one-cycle command stage and the read response register.
module counter_req_arbiter
    import counter_arb_pkg::*;
#(
    parameter int unsigned width = 8,
    parameter int unsigned nreq  = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [nreq-1:0]         REQ_VALID,
    input  logic [2*nreq-1:0]       REQ_OP,
    input  logic [width*nreq-1:0]   REQ_DATA,
    output logic [nreq-1:0]         REQ_READY,
    input  logic [width-1:0]        CNT_Q,
    output logic [width-1:0]        CNT_DATA_A,
    output logic                    CNT_ADDA,
    output logic [width-1:0]        CNT_DATA_B,
    output logic                    CNT_ADDB,
    output logic [width-1:0]        CNT_DATA_C,
    output logic                    CNT_SETC,
    output logic [width-1:0]        CNT_DATA_F,
    output logic                    CNT_SETF,
    output logic                    RSP_VALID,
    output logic [ptr_w(nreq)-1:0]  RSP_ID,
    output logic [width-1:0]        RSP_DATA
);

    localparam int unsigned PW = ptr_w(nreq);

    logic [PW-1:0]    ptr;
    logic [PW-1:0]    next_ptr;
    logic [nreq-1:0]  grant;
    logic             a_en, b_en, c_en, f_en, r_en;
    logic [PW-1:0]    a_idx, b_idx, c_idx, fr_idx;
    logic             stage_busy;
    logic [width-1:0] req_data [nreq];

    always_comb begin
        for (int unsigned i = 0; i < nreq; i++) begin
            req_data[i] = REQ_DATA[i*width +: width];
        end
    end

    assign stage_busy = CNT_ADDA | CNT_ADDB | CNT_SETC | CNT_SETF;
    assign REQ_READY  = RST ? '0 : grant;

    rr_scan #(
        .nreq (nreq),
        .pw   (PW)
    ) u_scan (
        .valid      (REQ_VALID),
        .op         (REQ_OP),
        .ptr        (ptr),
        .stage_busy (stage_busy),
        .grant      (grant),
        .a_en       (a_en),
        .a_idx      (a_idx),
        .b_en       (b_en),
        .b_idx      (b_idx),
        .c_en       (c_en),
        .c_idx      (c_idx),
        .f_en       (f_en),
        .r_en       (r_en),
        .fr_idx     (fr_idx),
        .next_ptr   (next_ptr)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr        <= '0;
            CNT_ADDA   <= 1'b0;
            CNT_DATA_A <= '0;
            CNT_ADDB   <= 1'b0;
            CNT_DATA_B <= '0;
            CNT_SETC   <= 1'b0;
            CNT_DATA_C <= '0;
            CNT_SETF   <= 1'b0;
            CNT_DATA_F <= '0;
            RSP_VALID  <= 1'b0;
            RSP_ID     <= '0;
            RSP_DATA   <= '0;
        end else begin
            ptr        <= next_ptr;
            CNT_ADDA   <= a_en;
            CNT_DATA_A <= a_en ? req_data[a_idx] : '0;
            CNT_ADDB   <= b_en;
            CNT_DATA_B <= b_en ? req_data[b_idx] : '0;
            CNT_SETC   <= c_en;
            CNT_DATA_C <= c_en ? req_data[c_idx] : '0;
            CNT_SETF   <= f_en;
            CNT_DATA_F <= f_en ? req_data[fr_idx] : '0;
            RSP_VALID  <= r_en;
            if (r_en) begin
                RSP_ID   <= fr_idx;
                RSP_DATA <= CNT_Q;
            end
        end
    end

endmodule

// File: tb/tb_counter_req_arbiter.sv
// Directed bench for counter_req_arbiter with a behavioural Counter attached.
module tb_counter_req_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [7:0]  req_op = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic [7:0]  cnt_q = '0;
    logic [7:0]  cnt_data_a, cnt_data_b, cnt_data_c, cnt_data_f;
    logic        cnt_adda, cnt_addb, cnt_setc, cnt_setf;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;
    logic        pl_en = 1'b0;
    logic [7:0]  pl_val = '0;
    int          checks = 0;
    int          errors = 0;

    counter_req_arbiter #(.width(8), .nreq(4)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(req_valid), .REQ_OP(req_op), .REQ_DATA(req_data), .REQ_READY(req_ready),
        .CNT_Q(cnt_q),
        .CNT_DATA_A(cnt_data_a), .CNT_ADDA(cnt_adda),
        .CNT_DATA_B(cnt_data_b), .CNT_ADDB(cnt_addb),
        .CNT_DATA_C(cnt_data_c), .CNT_SETC(cnt_setc),
        .CNT_DATA_F(cnt_data_f), .CNT_SETF(cnt_setf),
        .RSP_VALID(rsp_valid), .RSP_ID(rsp_id), .RSP_DATA(rsp_data)
    );

    always #5 CLK = ~CLK;

    // External Counter: not reset by RST, with a bench preload port.
    always @(posedge CLK) begin
        if (pl_en) cnt_q <= pl_val;
        else if (cnt_setf) cnt_q <= cnt_data_f;
        else cnt_q <= (cnt_setc ? cnt_data_c : cnt_q) + (cnt_adda ? cnt_data_a : 8'd0)
                      + (cnt_addb ? cnt_data_b : 8'd0);
    end

    task automatic set_req(input int i, input logic [1:0] op, input logic [7:0] d);
        req_valid[i]      = 1'b1;
        req_op[2*i +: 2]  = op;
        req_data[8*i +: 8] = d;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        req_valid = '0;
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic preload(input logic [7:0] v);
        pl_en = 1'b1;
        pl_val = v;
        @(posedge CLK);
        @(negedge CLK);
        pl_en = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) set_req(i, 2'b00, 8'(i + 1));
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready got %b want 0000", req_ready); end
        checks++;
        if ({cnt_adda, cnt_addb, cnt_setc, cnt_setf, cnt_data_a, cnt_data_b, cnt_data_c, cnt_data_f} !== '0 ||
            rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rst_cnt got en=%b%b%b%b rsp=%b want all 0",
                                cnt_adda, cnt_addb, cnt_setc, cnt_setf, rsp_valid);
        end
        @(negedge CLK);
        RST = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0011) begin errors++; $display("FAIL rst_first_grant got %b want 0011", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_pack();
        do_reset();
        preload(8'd0);
        set_req(0, 2'b00, 8'd5);
        set_req(1, 2'b00, 8'd7);
        set_req(2, 2'b01, 8'd10);
        #1;
        checks++;
        if (req_ready !== 4'b0111) begin errors++; $display("FAIL pack_ready got %b want 0111", req_ready); end
        @(posedge CLK);
        @(negedge CLK);
        req_valid = '0;
        #1;
        checks++;
        if ({cnt_adda, cnt_addb, cnt_setc, cnt_setf} !== 4'b1110 || cnt_data_a !== 8'd5 ||
            cnt_data_b !== 8'd7 || cnt_data_c !== 8'd10 || cnt_data_f !== 8'd0) begin
            errors++; $display("FAIL pack_stage got en=%b%b%b%b a=%0d b=%0d c=%0d f=%0d want 1110 5 7 10 0",
                                cnt_adda, cnt_addb, cnt_setc, cnt_setf, cnt_data_a, cnt_data_b, cnt_data_c, cnt_data_f);
        end
        // ptr should now be 3: all-ADD scan grants {3,0}
        for (int i = 0; i < 4; i++) set_req(i, 2'b00, 8'd0);
        #1;
        checks++;
        if (req_ready !== 4'b1001) begin errors++; $display("FAIL pack_ptr got %b want 1001", req_ready); end
        @(posedge CLK);
        @(negedge CLK);
        req_valid = '0;
        #1;
        checks++;
        if (cnt_q !== 8'd22) begin errors++; $display("FAIL pack_q got %0d want 22", cnt_q); end
    endtask

    task automatic test_wrap();
        do_reset();
        preload(8'd250);
        set_req(0, 2'b00, 8'd3);
        set_req(1, 2'b00, 8'd4);
        @(posedge CLK);
        @(negedge CLK);
        req_valid = '0;
        @(posedge CLK);
        @(negedge CLK);
        #1;
        checks++;
        if (cnt_q !== 8'd1) begin errors++; $display("FAIL wrap_q got %0d want 1", cnt_q); end
    endtask

    task automatic test_read_stall();
        do_reset();
        preload(8'd9);
        set_req(0, 2'b00, 8'd1);
        set_req(1, 2'b11, 8'd0);
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL rd_first got %b want 0001", req_ready); end
        @(posedge CLK);
        @(negedge CLK);
        req_valid[0] = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL rd_stall got %b want 0000", req_ready); end
        @(posedge CLK);
        @(negedge CLK);
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin errors++; $display("FAIL rd_grant got %b want 0010", req_ready); end
        @(posedge CLK);
        @(negedge CLK);
        req_valid = '0;
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 8'd10 || rsp_id !== 2'd1) begin
            errors++; $display("FAIL rd_rsp got v=%b d=%0d id=%0d want 1 10 1", rsp_valid, rsp_data, rsp_id);
        end
        @(negedge CLK);
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_rsp_pulse got %b want 0", rsp_valid); end
    endtask

    task automatic test_force();
        do_reset();
        preload(8'd0);
        set_req(0, 2'b10, 8'h55);
        set_req(1, 2'b00, 8'd2);
        set_req(2, 2'b00, 8'd3);
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL force_ready got %b want 0001", req_ready); end
        @(posedge CLK);
        @(negedge CLK);
        req_valid[0] = 1'b0;
        #1;
        checks++;
        if (cnt_setf !== 1'b1 || cnt_data_f !== 8'h55 || cnt_adda !== 1'b0 || cnt_addb !== 1'b0 ||
            cnt_setc !== 1'b0 || cnt_data_a !== 8'd0) begin
            errors++; $display("FAIL force_stage got f=%b df=%h a=%b b=%b c=%b da=%0d want 1 55 0 0 0 0",
                                cnt_setf, cnt_data_f, cnt_adda, cnt_addb, cnt_setc, cnt_data_a);
        end
        checks++;
        if (req_ready !== 4'b0110) begin errors++; $display("FAIL force_next got %b want 0110", req_ready); end
        @(posedge CLK);
        @(negedge CLK);
        req_valid = '0;
        #1;
        checks++;
        if (cnt_adda !== 1'b1 || cnt_addb !== 1'b1 || cnt_data_a !== 8'd2 || cnt_data_b !== 8'd3 ||
            cnt_setf !== 1'b0) begin
            errors++; $display("FAIL force_adds got a=%b b=%b da=%0d db=%0d f=%b want 1 1 2 3 0",
                                cnt_adda, cnt_addb, cnt_data_a, cnt_data_b, cnt_setf);
        end
        @(posedge CLK);
        @(negedge CLK);
        #1;
        checks++;
        if (cnt_q !== 8'h5a) begin errors++; $display("FAIL force_q got %h want 5a", cnt_q); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_rdy [4];
        exp_rdy = '{4'b0011, 4'b1100, 4'b0011, 4'b1100};
        do_reset();
        preload(8'd100);
        for (int i = 0; i < 4; i++) set_req(i, 2'b00, 8'(i + 1));
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (req_ready !== exp_rdy[c]) begin
                errors++; $display("FAIL b2b_ready[%0d] got %b want %b", c, req_ready, exp_rdy[c]);
            end
            @(posedge CLK);
            @(negedge CLK);
        end
        // Stage holds the {2,3} adds; reset drops them before the Counter sees them.
        req_valid = '0;
        RST = 1'b1;
        #1;
        checks++;
        if (cnt_adda !== 1'b0 || cnt_addb !== 1'b0 || cnt_data_a !== 8'd0 || req_ready !== 4'b0000) begin
            errors++; $display("FAIL b2b_rst_stage got a=%b b=%b da=%0d rdy=%b want 0 0 0 0000",
                                cnt_adda, cnt_addb, cnt_data_a, req_ready);
        end
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        checks++;
        if (cnt_q !== 8'd113) begin errors++; $display("FAIL b2b_q got %0d want 113", cnt_q); end
        for (int i = 0; i < 4; i++) set_req(i, 2'b00, 8'd0);
        #1;
        checks++;
        if (req_ready !== 4'b0011) begin errors++; $display("FAIL b2b_ptr_reset got %b want 0011", req_ready); end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_pack();
        test_wrap();
        test_read_stall();
        test_force();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
